// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, constants and the address legality check for the data-memory arbiter
package dmem_pkg;
   typedef enum logic [1:0] {INIT, IDLE, ACCESS} state_t;
   typedef logic req_idx_t;
   localparam int WORD_BYTES = 4;
   // Word access is legal when aligned and the last byte fits; the 33-bit sum makes a wrap past 2^32 illegal.
   function automatic logic addr_ok(input logic [31:0] a, input logic [31:0] mem_bytes);
      return (a[1:0] == 2'b00) && (({1'b0, a} + 33'(WORD_BYTES - 1)) < {1'b0, mem_bytes});
   endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter; on a tie the requester that is not ptr wins.
//   req[1:0] : request lines
//   ptr      : index of the most recent tie winner (register held by the parent)
//   gnt[1:0] : one-hot grant, or zero when nobody requests
module rr_arb2
   import dmem_pkg::*;
(
   input  logic [1:0] req,
   input  req_idx_t   ptr,
   output logic [1:0] gnt
);
   assign gnt = (&req) ? (ptr ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: sequences the DataMemory preload phase and shares its port between two requesters.
//   clk, rst                            : clock, synchronous active-high reset
//   req/we/addr/wdata 0,1               : requester inputs, held until gnt
//   gnt0/1, rvalid0/1, rdata, err       : accept pulse, completion pulse, shared read data, rejection flag
//   mem_address/writeData/memWrite/memRead/startin, mem_readData : DataMemory port
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int MEM_BYTES   = 128,
   parameter int INIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        rvalid0,
   output logic        rvalid1,
   output logic [31:0] rdata,
   output logic        err,
   output logic [31:0] mem_address,
   output logic [31:0] mem_writeData,
   output logic        mem_memWrite,
   output logic        mem_memRead,
   output logic        mem_startin,
   input  logic [31:0] mem_readData
);
   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   req_idx_t    ptr_q, ptr_d, idx_q, idx_d;
   logic        we_q, we_d, bad_q, bad_d, err_q, err_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [1:0]  rvalid_q, rvalid_d, arb_gnt, gnt;
   rr_arb2 u_arb (
      .req ({req1, req0}),
      .ptr (ptr_q),
      .gnt (arb_gnt)
   );
   // A grant seen during reset would be lost at the edge, so it is masked.
   assign gnt = (state_q == IDLE && !rst) ? arb_gnt : 2'b00;
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ptr_d    = ptr_q;
      idx_d    = idx_q;
      we_d     = we_q;
      bad_d    = bad_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rvalid_d = 2'b00;
      rdata_d  = '0;
      err_d    = 1'b0;
      if (state_q == INIT) begin
         cnt_d   = cnt_q + 32'd1;
         state_d = (cnt_q == 32'(INIT_CYCLES - 1)) ? IDLE : INIT;
      end else if (state_q == IDLE) begin
         if (|gnt) begin
            state_d = ACCESS;
            idx_d   = gnt[1];
            we_d    = gnt[1] ? we1 : we0;
            addr_d  = gnt[1] ? addr1 : addr0;
            wdata_d = gnt[1] ? wdata1 : wdata0;
            bad_d   = !addr_ok(addr_d, 32'(MEM_BYTES));
            // The pointer only moves when both requesters competed.
            ptr_d   = (req0 && req1) ? gnt[1] : ptr_q;
         end
      end else begin
         state_d         = IDLE;
         rvalid_d[idx_q] = 1'b1;
         err_d           = bad_q;
         rdata_d         = (!we_q && !bad_q) ? mem_readData : '0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= INIT;
         cnt_q    <= '0;
         ptr_q    <= 1'b1;
         idx_q    <= 1'b0;
         we_q     <= 1'b0;
         bad_q    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rvalid_q <= 2'b00;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ptr_q    <= ptr_d;
         idx_q    <= idx_d;
         we_q     <= we_d;
         bad_q    <= bad_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end
   assign gnt0          = gnt[0];
   assign gnt1          = gnt[1];
   assign rvalid0       = rvalid_q[0];
   assign rvalid1       = rvalid_q[1];
   assign rdata         = rdata_q;
   assign err           = err_q;
   assign mem_address   = addr_q;
   assign mem_writeData = wdata_q;
   // rst in the ACCESS cycle must keep the write from committing at that edge.
   assign mem_memWrite  = (state_q == ACCESS) && we_q && !bad_q && !rst;
   assign mem_memRead   = (state_q == ACCESS) && !we_q && !bad_q;
   assign mem_startin   = (state_q == INIT);
endmodule
